// File: rtl/jtag_rpc_out_reg.sv
// Host-to-core JTAG RPC data register: shifts a word in on tdi, commits it on Update-DR
// into a valid/ready slot, and reports delivery/overrun/length status through Capture-DR.
module jtag_rpc_out_reg #(
  parameter int              BITS        = 16,
  parameter logic [BITS-1:0] RESET_VALUE = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            select,
  input  logic            capture_dr,
  input  logic            shift_dr,
  input  logic            update_dr,
  input  logic            tdi,
  output logic            tdo,
  output logic [BITS-1:0] data_out,
  output logic            data_valid,
  input  logic            data_ready,
  output logic            overrun,
  output logic            len_err
);

  localparam int CNT_W = $clog2(BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BITS + 1);

  logic [BITS-1:0]  buffer;
  logic [CNT_W-1:0] cnt;

  logic do_capture;
  logic do_shift;
  logic do_update;
  logic commit;
  logic slot_free;
  logic load;
  logic drop;
  logic len_set;
  logic consume;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_SAT) ? CNT_SAT : c + CNT_W'(1);
  endfunction

  function automatic logic [BITS-1:0] status_word(input logic le, input logic ov, input logic dv);
    logic [BITS-1:0] w;
    w    = '0;
    w[0] = dv;
    w[1] = ov;
    w[2] = le;
    return w;
  endfunction

  // Update acts on the pre-edge buffer/cnt, independently of capture/shift
  assign do_capture = select & capture_dr;
  assign do_shift   = select & shift_dr & ~capture_dr;
  assign do_update  = select & update_dr;
  assign commit     = do_update & (cnt == CNT_FULL);
  assign len_set    = do_update & (cnt != CNT_FULL);
  assign slot_free  = ~data_valid | data_ready;
  assign load       = commit & slot_free;
  assign drop       = commit & ~slot_free;
  assign consume    = data_valid & data_ready;

  assign tdo = buffer[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer <= '0;
      cnt    <= '0;
    end else if (do_capture) begin
      buffer <= status_word(len_err, overrun, data_valid);
      cnt    <= '0;
    end else if (do_shift) begin
      buffer <= {tdi, buffer[BITS-1:1]};
      cnt    <= sat_inc(cnt);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= RESET_VALUE;
      data_valid <= 1'b0;
    end else if (load) begin
      data_out   <= buffer;
      data_valid <= 1'b1;
    end else if (consume) begin
      data_valid <= 1'b0;
    end
  end

  // Sticky flags: a set event in the capture cycle beats the read-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
      len_err <= 1'b0;
    end else begin
      if (drop)            overrun <= 1'b1;
      else if (do_capture) overrun <= 1'b0;
      if (len_set)         len_err <= 1'b1;
      else if (do_capture) len_err <= 1'b0;
    end
  end

endmodule
